mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
- Producer side of the operand-forwarding interface, sitting between EX and the register file.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory port.
- Publishes the destination register, write-enable and forwardable data of both stages to the forwarding unit.
- Generates the load-use stall (a load result in EX/MEM cannot be forwarded) and the data-memory wait stall.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  instruction in EX is real (not bubble)
- ex_rd  in  5  EX destination register
- ex_reg_write  in  1  EX writes register file
- ex_mem_read  in  1  EX is load
- ex_mem_write  in  1  EX is store
- ex_wd_sel  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 reserved (treated as ALU)
- ex_alu_result  in  XLEN  ALU result / memory address
- ex_store_data  in  XLEN  store data (already forwarded)
- ex_pc_plus4  in  XLEN  link value
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- dmem_rdata  in  XLEN  memory read data (valid when dmem_ready)
- dmem_ready  in  1  memory completes access this cycle
- dmem_addr, dmem_wdata  out  XLEN each  memory address / write data
- dmem_we, dmem_re  out  1 each  memory write / read strobes
- ex_mem_rd  out  5  EX/MEM destination register
- ex_mem_wb  out  1  EX/MEM valid and reg_write
- ex_mem_fwd_data  out  XLEN  EX/MEM forwardable value
- mem_wb_rd  out  5  MEM/WB destination register
- mem_wb_wb  out  1  MEM/WB valid and reg_write
- mem_wb_wdata  out  XLEN  MEM/WB writeback value (also forward data)
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- load_use_stall  out  1  load-use hazard detected
- mem_stall  out  1  memory wait in progress
- front_hold  out  1  freeze PC, IF/ID and ID/EX
- id_ex_bubble  out  1  insert bubble into ID/EX
- stall_cycles  out  CNT_W  cycles with front_hold=1
- retired  out  CNT_W  valid MEM/WB instructions

Behaviour:
- Reset (synchronous, rst=1 at clk edge): both stage valids=0, all stage fields=0, counters=0. All outputs therefore read 0 after reset; reset mid-stall discards the held instruction.
- mem_stall = em_valid & (em_mem_read | em_mem_write) & ~dmem_ready. This is combinational; a single-cycle memory never stalls.
- EX/MEM register:
  - If mem_stall, hold all fields.
  - Otherwise capture all EX fields, with valid = ex_valid.
- MEM/WB register:
  - If mem_stall, set valid=0 (bubble) and leave other fields don't-care.
  - Otherwise capture valid, rd, reg_write, and wdata = mux(em_wd_sel): 00/11 em_alu, 01 dmem_rdata, 10 em_pc4.
- Latency: EX result is visible on rf_* 2 cycles after capture, plus one cycle per wait cycle.
- Memory port outputs:
  - dmem_addr = em_alu, dmem_wdata = em_store.
  - dmem_we = em_valid & em_mem_write; dmem_re = em_valid & em_mem_read.
  - All memory outputs are stable for the full duration of a wait.
- Forwarding outputs:
  - ex_mem_wb = em_valid & em_reg_write.
  - ex_mem_fwd_data = em_pc4 if wd_sel=10, else em_alu.
  - mem_wb_wb = mw_valid & mw_reg_write.
  - x0 filtering is not applied here; the consumer applies it.
- Register-file port: rf_we = mw_valid & mw_reg_write & (mw_rd != 0); rf_waddr = mw_rd; rf_wdata = mw_wdata.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- Stall control:
  - front_hold = load_use_stall | mem_stall.
  - id_ex_bubble = load_use_stall & ~mem_stall.
  - On a simultaneous load-use and memory wait, ID/EX holds and is not bubbled.
  - The load-use stall lasts exactly one cycle absent mem_stall; the load then moves to EX/MEM and the hazard clears.
- Counters:
  - stall_cycles increments each cycle front_hold=1.
  - retired increments each cycle mw_valid=1.
  - Both wrap modulo 2^CNT_W.

Test Plan:
- ALU chain: add x5 (alu=0x10) then consumer → next cycle ex_mem_rd=5, ex_mem_wb=1, ex_mem_fwd_data=0x10; cycle after mem_wb_wdata=0x10, rf_we=1, rf_waddr=5.
- Load-use: EX lw x7, ID uses rs1=7 → load_use_stall=1, id_ex_bubble=1 for exactly 1 cycle. Same case with id_use_rs1=0 → no stall. Same case with ex_rd=0 → no stall.
- Memory wait: lw in EX/MEM with dmem_ready low for 3 cycles, rdata=0xCAFE → mem_stall=1 for 3 cycles; dmem_addr and dmem_re stable; MEM/WB bubbles (rf_we=0); then rf_wdata=0xCAFE; stall_cycles=3.
- Simultaneous load-use plus memory wait → front_hold=1, id_ex_bubble=0 while waiting; id_ex_bubble=1 for the first cycle after dmem_ready.
- JAL x1 with pc4=0x104 → ex_mem_fwd_data=0x104 and rf_wdata=0x104. Write to x0 → mem_wb_wb=1 but rf_we=0.
- Reset asserted mid-wait → next cycle all valids 0, dmem_re=0, mem_stall=0, counters 0.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers, data-memory port and
// producer side of operand forwarding with load-use / memory-wait stalls.
module mem_wb_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [1:0]       ex_wd_sel,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic [XLEN-1:0]  ex_pc_plus4,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ready,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic             dmem_we,
  output logic             dmem_re,
  output logic [4:0]       ex_mem_rd,
  output logic             ex_mem_wb,
  output logic [XLEN-1:0]  ex_mem_fwd_data,
  output logic [4:0]       mem_wb_rd,
  output logic             mem_wb_wb,
  output logic [XLEN-1:0]  mem_wb_wdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             load_use_stall,
  output logic             mem_stall,
  output logic             front_hold,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] retired
);

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      wd_sel;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] pc4;
  } em_t;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            reg_write;
    logic [XLEN-1:0] wdata;
  } mw_t;

  em_t             em_q, em_d;
  mw_t             mw_q, mw_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [XLEN-1:0]  wb_sel;
  logic             rs1_hit, rs2_hit;

  assign mem_stall = em_q.valid
                   & (em_q.mem_read | em_q.mem_write)
                   & ~dmem_ready;

  assign rs1_hit = id_use_rs1 & (ex_rd == id_rs1);
  assign rs2_hit = id_use_rs2 & (ex_rd == id_rs2);

  assign load_use_stall = ex_valid & ex_mem_read
                        & (ex_rd != 5'd0)
                        & (rs1_hit | rs2_hit);

  // During a memory wait ID/EX must hold, so the bubble is deferred.
  assign front_hold   = load_use_stall | mem_stall;
  assign id_ex_bubble = load_use_stall & ~mem_stall;

  always_comb begin
    unique case (em_q.wd_sel)
      2'b01:   wb_sel = dmem_rdata;
      2'b10:   wb_sel = em_q.pc4;
      default: wb_sel = em_q.alu;
    endcase
  end

  always_comb begin
    em_d = em_q;
    mw_d = mw_q;
    if (mem_stall) begin
      mw_d.valid = 1'b0;
    end else begin
      em_d.valid     = ex_valid;
      em_d.rd        = ex_rd;
      em_d.reg_write = ex_reg_write;
      em_d.mem_read  = ex_mem_read;
      em_d.mem_write = ex_mem_write;
      em_d.wd_sel    = ex_wd_sel;
      em_d.alu       = ex_alu_result;
      em_d.store     = ex_store_data;
      em_d.pc4       = ex_pc_plus4;
      mw_d.valid     = em_q.valid;
      mw_d.rd        = em_q.rd;
      mw_d.reg_write = em_q.reg_write;
      mw_d.wdata     = wb_sel;
    end
  end

  always_comb begin
    stall_d = stall_q + CNT_W'(front_hold);
    ret_d   = ret_q + CNT_W'(mw_q.valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_q    <= '0;
      mw_q    <= '0;
      stall_q <= '0;
      ret_q   <= '0;
    end else begin
      em_q    <= em_d;
      mw_q    <= mw_d;
      stall_q <= stall_d;
      ret_q   <= ret_d;
    end
  end

  assign dmem_addr  = em_q.alu;
  assign dmem_wdata = em_q.store;
  assign dmem_we    = em_q.valid & em_q.mem_write;
  assign dmem_re    = em_q.valid & em_q.mem_read;

  assign ex_mem_rd       = em_q.rd;
  assign ex_mem_wb       = em_q.valid & em_q.reg_write;
  assign ex_mem_fwd_data = (em_q.wd_sel == 2'b10) ? em_q.pc4
                                                  : em_q.alu;

  assign mem_wb_rd    = mw_q.rd;
  assign mem_wb_wb    = mw_q.valid & mw_q.reg_write;
  assign mem_wb_wdata = mw_q.wdata;

  assign rf_we    = mem_wb_wb & (mw_q.rd != 5'd0);
  assign rf_waddr = mw_q.rd;
  assign rf_wdata = mw_q.wdata;

  assign stall_cycles = stall_q;
  assign retired      = ret_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: forwarding, stalls,
// memory wait, link writeback and reset behaviour.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_reg_write;
  logic        ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wd_sel;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [31:0] ex_pc_plus4;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_we, dmem_re;
  logic [4:0]  ex_mem_rd, mem_wb_rd, rf_waddr;
  logic        ex_mem_wb, mem_wb_wb, rf_we;
  logic [31:0] ex_mem_fwd_data, mem_wb_wdata, rf_wdata;
  logic        load_use_stall, mem_stall;
  logic        front_hold, id_ex_bubble;
  logic [31:0] stall_cycles, retired;

  int n_chk  = 0;
  int n_pass = 0;

  mem_wb_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_wd_sel(ex_wd_sel),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_pc_plus4(ex_pc_plus4),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wb(ex_mem_wb),
    .ex_mem_fwd_data(ex_mem_fwd_data),
    .mem_wb_rd(mem_wb_rd), .mem_wb_wb(mem_wb_wb),
    .mem_wb_wdata(mem_wb_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .load_use_stall(load_use_stall),
    .mem_stall(mem_stall),
    .front_hold(front_hold),
    .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h",
                  tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd,
                        input logic rw, input logic mr,
                        input logic mw, input logic [1:0] sel,
                        input logic [31:0] alu,
                        input logic [31:0] st,
                        input logic [31:0] pc4);
    ex_valid      = v;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_wd_sel     = sel;
    ex_alu_result = alu;
    ex_store_data = st;
    ex_pc_plus4   = pc4;
  endtask

  task automatic bubble();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_use_rs1 = 0;
    id_use_rs2 = 0;
    id_rs1 = 0;
    id_rs2 = 0;
  endtask

  initial begin
    rst = 1;
    bubble();
    dmem_rdata = 0;
    dmem_ready = 1;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_exm_wb", ex_mem_wb, 0);
    chk("rst_mwb_wb", mem_wb_wb, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_re", dmem_re, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_ret", retired, 0);

    // ALU chain: add x5 = 0x10
    set_ex(1, 5, 1, 0, 0, 2'b00, 32'h10, 0, 32'h8);
    tick();
    bubble();
    #1;
    chk("alu_em_rd", ex_mem_rd, 5);
    chk("alu_em_wb", ex_mem_wb, 1);
    chk("alu_fwd", ex_mem_fwd_data, 32'h10);
    chk("alu_re", dmem_re, 0);
    tick();
    chk("alu_mw_wd", mem_wb_wdata, 32'h10);
    chk("alu_rf_we", rf_we, 1);
    chk("alu_rf_wa", rf_waddr, 5);
    chk("alu_mw_wb", mem_wb_wb, 1);
    tick();
    chk("alu_ret", retired, 1);
    chk("alu_rf_we0", rf_we, 0);

    // Load-use: lw x7 in EX
    set_ex(1, 7, 1, 1, 0, 2'b01, 32'h200, 0, 0);
    id_rs1 = 7;
    id_use_rs1 = 0;
    #1;
    chk("lu_nouse", load_use_stall, 0);
    id_use_rs1 = 1;
    ex_rd = 0;
    #1;
    chk("lu_x0", load_use_stall, 0);
    ex_rd = 7;
    id_use_rs1 = 0;
    id_rs2 = 7;
    id_use_rs2 = 1;
    #1;
    chk("lu_rs2", load_use_stall, 1);
    id_use_rs2 = 0;
    id_use_rs1 = 1;
    #1;
    chk("lu_stall", load_use_stall, 1);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_hold", front_hold, 1);
    tick();
    bubble();
    dmem_rdata = 32'h1234;
    #1;
    chk("lu_clear", load_use_stall, 0);
    chk("lu_bub_clr", id_ex_bubble, 0);
    chk("lu_re", dmem_re, 1);
    chk("lu_stallcnt", stall_cycles, 1);
    tick();
    chk("lu_wdata", rf_wdata, 32'h1234);
    chk("lu_waddr", rf_waddr, 7);

    // Memory wait: lw x9, three wait cycles
    set_ex(1, 9, 1, 1, 0, 2'b01, 32'h300, 0, 0);
    dmem_ready = 0;
    tick();
    bubble();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mw_stall", mem_stall, 1);
      chk("mw_addr", dmem_addr, 32'h300);
      chk("mw_re", dmem_re, 1);
      chk("mw_rf_we", rf_we, 0);
      tick();
    end
    dmem_ready = 1;
    dmem_rdata = 32'hCAFE;
    #1;
    chk("mw_go", mem_stall, 0);
    chk("mw_stallcnt", stall_cycles, 4);
    tick();
    chk("mw_wdata", rf_wdata, 32'hCAFE);
    chk("mw_waddr", rf_waddr, 9);
    chk("mw_rf_we1", rf_we, 1);
    tick();
    chk("mw_ret", retired, 3);

    // Load-use while lw x10 waits on memory
    set_ex(1, 10, 1, 1, 0, 2'b01, 32'h400, 0, 0);
    dmem_ready = 0;
    tick();
    set_ex(1, 11, 1, 1, 0, 2'b01, 32'h500, 0, 0);
    id_rs1 = 11;
    id_use_rs1 = 1;
    #1;
    chk("sim_lu", load_use_stall, 1);
    chk("sim_ms", mem_stall, 1);
    chk("sim_hold", front_hold, 1);
    chk("sim_bub0", id_ex_bubble, 0);
    tick();
    chk("sim_hold2", front_hold, 1);
    chk("sim_bub0b", id_ex_bubble, 0);
    chk("sim_addr", dmem_addr, 32'h400);
    dmem_ready = 1;
    dmem_rdata = 32'h55;
    #1;
    chk("sim_bub1", id_ex_bubble, 1);
    chk("sim_ms0", mem_stall, 0);
    tick();
    bubble();
    dmem_rdata = 32'h77;
    #1;
    chk("sim_wd10", rf_wdata, 32'h55);
    chk("sim_wa10", rf_waddr, 10);
    chk("sim_em11", ex_mem_rd, 11);
    chk("sim_addr11", dmem_addr, 32'h500);
    chk("sim_bub_end", id_ex_bubble, 0);
    tick();
    chk("sim_wd11", rf_wdata, 32'h77);
    chk("sim_wa11", rf_waddr, 11);

    // JAL x1 link value, then reserved sel writing x0
    set_ex(1, 1, 1, 0, 0, 2'b10, 32'hDEAD, 0, 32'h104);
    tick();
    set_ex(1, 0, 1, 0, 0, 2'b11, 32'h33, 0, 32'h99);
    #1;
    chk("jal_fwd", ex_mem_fwd_data, 32'h104);
    tick();
    bubble();
    #1;
    chk("jal_rf_wd", rf_wdata, 32'h104);
    chk("jal_rf_we", rf_we, 1);
    chk("x0_fwd", ex_mem_fwd_data, 32'h33);
    chk("x0_em_wb", ex_mem_wb, 1);
    chk("x0_em_rd", ex_mem_rd, 0);
    tick();
    chk("x0_mw_wb", mem_wb_wb, 1);
    chk("x0_rf_we", rf_we, 0);
    chk("x0_mw_wd", mem_wb_wdata, 32'h33);

    // Reset in the middle of a memory wait
    set_ex(1, 12, 1, 1, 0, 2'b01, 32'h600, 0, 0);
    dmem_ready = 0;
    tick();
    bubble();
    tick();
    chk("rw_stall", mem_stall, 1);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rw_ms", mem_stall, 0);
    chk("rw_re", dmem_re, 0);
    chk("rw_em_wb", ex_mem_wb, 0);
    chk("rw_mw_wb", mem_wb_wb, 0);
    chk("rw_stallcnt", stall_cycles, 0);
    chk("rw_ret", retired, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
